ext_pipe: RTL and testbench

Parametrised, pipelined immediate/bit extender for the datapath. It generalises the single-bit 32-way replicator into a four-mode IN_W→OUT_W unit (zero, sign, upper-place, bit-replicate). Operands pass through a registered valid/ready stage with a one-entry skid buffer, so the unit sits between decode and the ALU operand mux without breaking the handshake timing path.

---
 rtl/ext_pipe.sv | 128 ++++++++++++
 tb/tb_ext_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ext_pipe.sv
// ext_pipe: pipelined IN_W->OUT_W extender (zero / sign / upper / replicate)
// behind a registered valid/ready stage with a one-entry skid buffer.
// Build option: define EXT_PIPE_CNT_EN to add the saturating xfer_cnt
// output that counts accepted results.
module ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
`ifdef EXT_PIPE_CNT_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [OUT_W-1:0] ext_data;
  logic [OUT_W-1:0] main_q;
  logic [OUT_W-1:0] skid_q;
  logic             in_xfer;
  logic             out_xfer;
  logic             load_main_ext;
  logic             load_main_skid;
  logic             load_skid;

  // Handshake flags come straight from the state register, so out_ready
  // never reaches in_ready combinationally.
  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Extension function applied to the operand being offered.
  always_comb begin
    ext_data = '0;
    case (in_mode)
      2'b00:   ext_data = {{(OUT_W-IN_W){1'b0}}, in_data};
      2'b01:   ext_data = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
      2'b10:   ext_data = {in_data, {(OUT_W-IN_W){1'b0}}};
      default: ext_data = {OUT_W{in_data[0]}};
    endcase
  end

  // Next-state and data-load decode; flush wins over any input transfer.
  always_comb begin
    state_nxt      = state;
    load_main_ext  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            load_main_ext = 1'b1;
            state_nxt     = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_xfer && out_xfer) begin
            load_main_ext = 1'b1;
          end else if (in_xfer) begin
            load_skid = 1'b1;
            state_nxt = ST_FULL;
          end else if (out_xfer) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            load_main_skid = 1'b1;
            state_nxt      = ST_BUSY;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Data registers are never cleared; out_valid qualifies their contents.
  always_ff @(posedge clk) begin
    if (load_main_ext) begin
      main_q <= ext_data;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
    if (load_skid) begin
      skid_q <= ext_data;
    end
  end

`ifdef EXT_PIPE_CNT_EN
  // Saturating count of delivered results; flush-cycle deliveries still count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= 16'd0;
    end else if (out_xfer && (xfer_cnt != 16'hFFFF)) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: table-driven mode vectors, directed corner sequences and
// randomized traffic for ext_pipe, compared against a queue-based model.
module tb_ext_pipe;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
`ifdef EXT_PIPE_CNT_EN
  logic [15:0]      xfer_cnt;
`endif

  int n_vec;
  int n_err;

  logic [OUT_W-1:0] ref_q[$];
  int               ref_cnt;

  typedef struct {
    logic [IN_W-1:0]  data;
    logic [1:0]       mode;
    logic [OUT_W-1:0] expected;
  } vec_t;

  vec_t vecs[5];

  ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef EXT_PIPE_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference extension computed arithmetically from the mode rules.
  function automatic logic [OUT_W-1:0] ref_ext(input logic [IN_W-1:0] d, input logic [1:0] m);
    longint v;
    longint res;
    v = longint'(d);
    case (m)
      2'd0:    res = v;
      2'd1:    res = (v >= (longint'(1) << (IN_W-1))) ? v + ((longint'(1) << OUT_W) - (longint'(1) << IN_W)) : v;
      2'd2:    res = v * (longint'(1) << (OUT_W-IN_W));
      default: res = ((v % 2) == 1) ? (longint'(1) << OUT_W) - 1 : 0;
    endcase
    return res[OUT_W-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs against the model's view of the buffered results.
  task automatic checkOutput();
    check("in_ready", 64'(in_ready), 64'(ref_q.size() < 2));
    check("out_valid", 64'(out_valid), 64'(ref_q.size() > 0));
    if (ref_q.size() > 0) check("out_data", 64'(out_data), 64'(ref_q[0]));
`ifdef EXT_PIPE_CNT_EN
    check("xfer_cnt", 64'(xfer_cnt), 64'(ref_cnt));
`endif
  endtask

  // Called at a falling edge: drive inputs, check, advance model, wait one cycle.
  task automatic applyStimulus(input logic iv, input logic [IN_W-1:0] d, input logic [1:0] m,
                               input logic ordy, input logic fl);
    logic acc;
    logic dlv;
    in_valid  = iv;
    in_data   = d;
    in_mode   = m;
    out_ready = ordy;
    flush     = fl;
    #1;
    checkOutput();
    acc = iv && (ref_q.size() < 2);
    dlv = ordy && (ref_q.size() > 0);
    if (dlv) begin
      void'(ref_q.pop_front());
      if (ref_cnt < 65535) ref_cnt++;
    end
    if (fl) ref_q.delete();
    else if (acc) ref_q.push_back(ref_ext(d, m));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    ref_cnt = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_mode = 2'b00;
    out_ready = 1'b0;

    vecs[0] = '{16'h8001, 2'b00, 32'h00008001};
    vecs[1] = '{16'h8001, 2'b01, 32'hFFFF8001};
    vecs[2] = '{16'h8001, 2'b10, 32'h80010000};
    vecs[3] = '{16'h8001, 2'b11, 32'hFFFFFFFF};
    vecs[4] = '{16'h7FFE, 2'b11, 32'h00000000};

    #12;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
`ifdef EXT_PIPE_CNT_EN
    check("reset_xfer_cnt", 64'(xfer_cnt), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Mode table: each result visible one edge after acceptance.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, vecs[i].data, vecs[i].mode, 1'b1, 1'b0);
      check($sformatf("table%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("table%0d_data", i), 64'(out_data), 64'(vecs[i].expected));
    end
    idle(2);

    // Back-to-back: eight operands, one per cycle, in_ready stays high.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, IN_W'($urandom), 2'($urandom), 1'b1, 1'b0);
      check("b2b_in_ready", 64'(in_ready), 64'd1);
    end
    idle(2);

    // Stall: A and B accepted, C held off until the consumer drains.
    applyStimulus(1'b1, 16'hAAAA, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hBBBB, 2'b00, 1'b0, 1'b0);
    check("stall_full", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 16'hCCCC, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hCCCC, 2'b00, 1'b0, 1'b0);
    check("stall_hold_A", 64'(out_data), 64'h0000AAAA);
    applyStimulus(1'b1, 16'hCCCC, 2'b00, 1'b1, 1'b0);
    check("stall_B", 64'(out_data), 64'h0000BBBB);
    applyStimulus(1'b1, 16'hCCCC, 2'b00, 1'b1, 1'b0);
    check("stall_C", 64'(out_data), 64'h0000CCCC);
    idle(2);

    // Flush while full with an operand offered: that operand never appears.
    applyStimulus(1'b1, 16'h1111, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h2222, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h3333, 2'b01, 1'b0, 1'b1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    idle(3);

    // Flush in BUSY with simultaneous delivery and offered operand.
    applyStimulus(1'b1, 16'h4444, 2'b10, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h5555, 2'b10, 1'b1, 1'b1);
    idle(2);

    // Asynchronous reset in the middle of a cycle while BUSY.
    applyStimulus(1'b1, 16'h6666, 2'b00, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
`ifdef EXT_PIPE_CNT_EN
    check("async_rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
`endif
    ref_q.delete();
    ref_cnt = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), IN_W'($urandom), 2'($urandom),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    end
    idle(3);

`ifdef EXT_PIPE_CNT_EN
    // Drive the counter into saturation and confirm it sticks.
    for (int i = 0; i < 65540; i++) applyStimulus(1'b1, IN_W'(i), 2'b00, 1'b1, 1'b0);
    idle(3);
    check("cnt_saturated", 64'(xfer_cnt), 64'h000000000000FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
